// File: rtl/flash_seq_pkg.sv
// Shared opcodes, sequencer state encoding and small constant helpers for flash_seq.
package flash_seq_pkg;

    localparam logic [4:0] OP_READ  = 5'b01100;
    localparam logic [4:0] OP_WRITE = 5'b10100;
    localparam logic [4:0] OP_RESET = 5'b11100;
    localparam logic [4:0] OP_ARM   = 5'b11101;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        WR_DATA,
        WR_PULSE,
        WR_REC,
        RST_PULSE,
        RST_REC
    } seqState_t;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/flash_seq_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module flash_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/flash_seq.sv
// Parallel NOR flash command sequencer: burst read/write, plus a flash reset that
// only fires inside a short window opened by a separate arm command.
module flash_seq
    import flash_seq_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int T_RD   = 3,
    parameter int T_WR   = 4,
    parameter int T_RST  = 16,
    parameter int ARM_TO = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic [DATA_W-1:0] flash_dq_in,
    output logic [DATA_W-1:0] flash_dq_out,
    output logic              flash_dq_oe,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_rst_n,
    output logic              busy,
    output logic              err
);

    localparam int TW = $clog2(maxOf3(T_RD, T_WR, T_RST) + 1);
    localparam int AW = $clog2(ARM_TO + 1);

    seqState_t state, nextState;

    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  lenCnt;
    logic [DATA_W-1:0] rdDataQ, dqOutQ;
    logic              rdValidQ, errQ;
    logic              armed;
    logic [AW-1:0]     armCnt;
    logic              tmrLoad, tmrDone;
    logic [TW-1:0]     tmrVal;
    logic              accept, opLegal;

    assign cmd_ready = (state == IDLE) && rst_n;
    assign accept    = cmd_valid && cmd_ready;
    assign opLegal   = (cmd_op == OP_READ) || (cmd_op == OP_WRITE) ||
                       (cmd_op == OP_RESET) || (cmd_op == OP_ARM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_READ)                nextState = RD_WAIT;
                    else if (cmd_op == OP_WRITE)          nextState = WR_DATA;
                    else if (cmd_op == OP_RESET && armed) nextState = RST_PULSE;
                end
            end
            RD_WAIT:   if (tmrDone) nextState = RD_CAP;
            RD_CAP:    nextState = (lenCnt != '0) ? RD_WAIT : IDLE;
            WR_DATA:   if (wr_valid) nextState = WR_PULSE;
            WR_PULSE:  if (tmrDone) nextState = WR_REC;
            WR_REC:    nextState = (lenCnt != '0) ? WR_DATA : IDLE;
            RST_PULSE: if (tmrDone) nextState = RST_REC;
            RST_REC:   if (tmrDone) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // Timer loads on entry so a state lasts loadVal+1 cycles; RD_CAP->RD_WAIT counts as entry.
    always_comb begin
        tmrLoad = 1'b0;
        tmrVal  = '0;
        if (nextState != state) begin
            case (nextState)
                RD_WAIT:   begin tmrLoad = 1'b1; tmrVal = TW'(T_RD - 1);  end
                WR_PULSE:  begin tmrLoad = 1'b1; tmrVal = TW'(T_WR - 1);  end
                RST_PULSE,
                RST_REC:   begin tmrLoad = 1'b1; tmrVal = TW'(T_RST - 1); end
                default:   begin tmrLoad = 1'b0; tmrVal = '0;             end
            endcase
        end
    end

    flash_seq_timer #(.W(TW)) uTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmrLoad),
        .loadVal (tmrVal),
        .done    (tmrDone)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            lenCnt   <= '0;
            rdDataQ  <= '0;
            rdValidQ <= 1'b0;
            dqOutQ   <= '0;
            errQ     <= 1'b0;
            armed    <= 1'b0;
            armCnt   <= '0;
        end else begin
            rdValidQ <= 1'b0;
            errQ     <= 1'b0;
            if (accept) begin
                addr   <= cmd_addr;
                lenCnt <= cmd_len;
            end
            if (state == RD_CAP) begin
                rdDataQ  <= flash_dq_in;
                rdValidQ <= 1'b1;
            end
            if ((state == RD_CAP || state == WR_REC) && lenCnt != '0) begin
                addr   <= addr + ADDR_W'(1);
                lenCnt <= lenCnt - 1'b1;
            end
            if (state == WR_DATA && wr_valid) begin
                dqOutQ <= wr_data;
            end
            // Acceptance is checked before expiry, so a reset landing on the last armed cycle still runs.
            if (accept) begin
                errQ <= !opLegal || (cmd_op == OP_RESET && !armed);
                if (cmd_op == OP_ARM) begin
                    armed  <= 1'b1;
                    armCnt <= AW'(ARM_TO);
                end else begin
                    armed <= 1'b0;
                end
            end else if (armed) begin
                if (armCnt == AW'(1)) armed <= 1'b0;
                armCnt <= armCnt - 1'b1;
            end
        end
    end

    always_comb begin
        flash_ce_n  = 1'b1;
        flash_oe_n  = 1'b1;
        flash_we_n  = 1'b1;
        flash_rst_n = 1'b1;
        flash_dq_oe = 1'b0;
        wr_ready    = 1'b0;
        case (state)
            RD_WAIT, RD_CAP: begin
                flash_ce_n = 1'b0;
                flash_oe_n = 1'b0;
            end
            WR_DATA:   wr_ready = 1'b1;
            WR_PULSE: begin
                flash_ce_n  = 1'b0;
                flash_we_n  = 1'b0;
                flash_dq_oe = 1'b1;
            end
            WR_REC: begin
                flash_ce_n  = 1'b0;
                flash_dq_oe = 1'b1;
            end
            RST_PULSE: flash_rst_n = 1'b0;
            default: ;
        endcase
    end

    assign busy         = (state != IDLE);
    assign err          = errQ;
    assign rd_data      = rdDataQ;
    assign rd_valid     = rdValidQ;
    assign flash_addr   = addr;
    assign flash_dq_out = dqOutQ;

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq with read/write scoreboards and strobe activity counters.
module tb_flash_seq;
    import flash_seq_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;
    localparam int T_RD   = 3;
    localparam int T_WR   = 4;
    localparam int T_RST  = 16;
    localparam int ARM_TO = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [4:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] flash_addr;
    logic [DATA_W-1:0] flash_dq_in;
    logic [DATA_W-1:0] flash_dq_out;
    logic              flash_dq_oe, flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n;
    logic              busy, err;

    always #5 clk = ~clk;

    // Flash model: each location reads back its own low address bits.
    assign flash_dq_in = flash_addr[DATA_W-1:0];

    flash_seq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .T_RD(T_RD), .T_WR(T_WR), .T_RST(T_RST), .ARM_TO(ARM_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .flash_addr(flash_addr), .flash_dq_in(flash_dq_in),
        .flash_dq_out(flash_dq_out), .flash_dq_oe(flash_dq_oe),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
        .flash_we_n(flash_we_n), .flash_rst_n(flash_rst_n),
        .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wrExp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DATA_W-1:0] rdQ[$];
    wrExp_t            wrQ[$];
    int                rdTimes[$];
    int weRun = 0, weLowCnt = 0, oeLowCnt = 0, ceLowCnt = 0;
    int rstLowCnt = 0, busyCnt = 0, errCnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!flash_we_n)  weLowCnt++;
        if (!flash_oe_n)  oeLowCnt++;
        if (!flash_ce_n)  ceLowCnt++;
        if (!flash_rst_n) rstLowCnt++;
        if (busy)         busyCnt++;
        if (err)          errCnt++;
        if (rst_n) begin
            check("oe_we_exclusive", {31'b0, !(!flash_oe_n && !flash_we_n)}, 32'd1);
            if (rd_valid) begin
                rdTimes.push_back(cyc);
                if (rdQ.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rd_data", {16'b0, rd_data}, {16'b0, rdQ.pop_front()});
            end
            if (!flash_we_n) begin
                weRun++;
            end else if (weRun != 0) begin
                if (wrQ.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    wrExp_t e;
                    e = wrQ.pop_front();
                    check("we_len", weRun, T_WR);
                    check("wr_addr", {12'b0, flash_addr}, {12'b0, e.a});
                    check("wr_data", {16'b0, flash_dq_out}, {16'b0, e.d});
                end
                weRun = 0;
            end
        end else begin
            weRun = 0;
        end
    end

    task automatic sendCmd(input logic [4:0] op, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        int n = 0;
        while (!cmd_ready && n < 4000) begin @(negedge clk); n++; end
        check("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic writeBeat(input logic [DATA_W-1:0] d);
        int n = 0;
        while (!wr_ready && n < 200) begin @(negedge clk); n++; end
        check("wr_ready_wait", {31'b0, wr_ready}, 32'd1);
        wr_valid = 1'b1; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while (busy && n < limit) begin @(negedge clk); n++; end
        check("idle_wait", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0, e0, r0, b0, o0, w0, c0;
        logic [ADDR_W-1:0] a;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
        check("rst_flash_rst_n", {31'b0, flash_rst_n}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rel_strobes", {28'b0, flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n}, 32'hF);
        check("rel_misc", {27'b0, flash_dq_oe, rd_valid, wr_ready, busy, err}, 32'd0);
        check("rel_addr", {12'b0, flash_addr}, 32'd0);
        check("rel_dq_out", {16'b0, flash_dq_out}, 32'd0);
        check("rel_rd_data", {16'b0, rd_data}, 32'd0);

        // Three-beat read, beats T_RD+1 cycles apart.
        rdQ.push_back(16'h0010); rdQ.push_back(16'h0011); rdQ.push_back(16'h0012);
        t0 = rdTimes.size();
        sendCmd(OP_READ, 20'h00010, 8'd2);
        waitIdle(100);
        check("rd3_left", rdQ.size(), 32'd0);
        check("rd3_count", rdTimes.size() - t0, 32'd3);
        if (rdTimes.size() - t0 == 3) begin
            check("rd3_gap0", rdTimes[t0+1] - rdTimes[t0], T_RD + 1);
            check("rd3_gap1", rdTimes[t0+2] - rdTimes[t0+1], T_RD + 1);
        end

        // Two-beat write wrapping the address counter.
        o0 = oeLowCnt; w0 = weLowCnt;
        wrQ.push_back('{a: 20'hFFFFF, d: 16'hA5A5});
        wrQ.push_back('{a: 20'h00000, d: 16'h5A5A});
        sendCmd(OP_WRITE, 20'hFFFFF, 8'd1);
        writeBeat(16'hA5A5);
        writeBeat(16'h5A5A);
        waitIdle(100);
        check("wr_left", wrQ.size(), 32'd0);
        check("wr_oe_quiet", oeLowCnt - o0, 32'd0);
        check("wr_we_total", weLowCnt - w0, 2 * T_WR);

        // Flash reset without arm is rejected.
        e0 = errCnt; r0 = rstLowCnt;
        sendCmd(OP_RESET, '0, '0);
        repeat (3) @(negedge clk);
        check("unarmed_err", errCnt - e0, 32'd1);
        check("unarmed_no_rst", rstLowCnt - r0, 32'd0);
        check("unarmed_busy", {31'b0, busy}, 32'd0);

        // Arm then reset.
        sendCmd(OP_ARM, '0, '0);
        check("arm_busy", {31'b0, busy}, 32'd0);
        e0 = errCnt; r0 = rstLowCnt; b0 = busyCnt;
        sendCmd(OP_RESET, '0, '0);
        waitIdle(200);
        check("armed_rst_len", rstLowCnt - r0, T_RST);
        check("armed_busy_len", busyCnt - b0, 2 * T_RST);
        check("armed_no_err", errCnt - e0, 32'd0);

        // Arm window expires.
        sendCmd(OP_ARM, '0, '0);
        repeat (ARM_TO + 1) @(negedge clk);
        e0 = errCnt; r0 = rstLowCnt;
        sendCmd(OP_RESET, '0, '0);
        repeat (3) @(negedge clk);
        check("expired_err", errCnt - e0, 32'd1);
        check("expired_no_rst", rstLowCnt - r0, 32'd0);

        // An intervening single-beat read disarms.
        sendCmd(OP_ARM, '0, '0);
        rdQ.push_back(16'h0055);
        t0 = rdTimes.size();
        sendCmd(OP_READ, 20'h00055, 8'd0);
        waitIdle(100);
        check("len0_beats", rdTimes.size() - t0, 32'd1);
        e0 = errCnt; r0 = rstLowCnt;
        sendCmd(OP_RESET, '0, '0);
        repeat (3) @(negedge clk);
        check("disarm_err", errCnt - e0, 32'd1);
        check("disarm_no_rst", rstLowCnt - r0, 32'd0);

        // Illegal opcode.
        e0 = errCnt; c0 = ceLowCnt;
        sendCmd(5'b00000, 20'h00123, 8'd4);
        repeat (3) @(negedge clk);
        check("illegal_err", errCnt - e0, 32'd1);
        check("illegal_ready", {31'b0, cmd_ready}, 32'd1);
        check("illegal_no_ce", ceLowCnt - c0, 32'd0);
        check("illegal_busy", {31'b0, busy}, 32'd0);

        // Maximum-length read across the address wrap.
        for (int i = 0; i < 256; i++) begin
            a = 20'hFFF80 + ADDR_W'(i);
            rdQ.push_back(a[DATA_W-1:0]);
        end
        t0 = rdTimes.size();
        sendCmd(OP_READ, 20'hFFF80, 8'hFF);
        waitIdle(3000);
        check("maxlen_beats", rdTimes.size() - t0, 32'd256);
        check("maxlen_left", rdQ.size(), 32'd0);

        // Module reset in the middle of a write pulse.
        sendCmd(OP_WRITE, 20'h00123, 8'd0);
        writeBeat(16'hBEEF);
        @(negedge clk);
        check("midwr_we_low", {31'b0, flash_we_n}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midwr_strobes", {29'b0, flash_we_n, flash_ce_n, flash_rst_n}, 32'h7);
        check("midwr_oe_busy", {30'b0, flash_dq_oe, busy}, 32'd0);
        check("midwr_ready_low", {31'b0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midwr_addr", {12'b0, flash_addr}, 32'd0);
        check("midwr_dq_out", {16'b0, flash_dq_out}, 32'd0);
        check("midwr_ready", {31'b0, cmd_ready}, 32'd1);
        check("total_rst_low", rstLowCnt, T_RST);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_seq.md
FLASH_SEQ -- requirements
Module: flash_seq

Interface
REQ-001 Parameter ADDR_W, 20, flash address width; address counter wraps modulo 2^ADDR_W.
REQ-002 Parameter DATA_W, 16, flash data width.
REQ-003 Parameter LEN_W, 8, burst length field width; beats = cmd_len+1.
REQ-004 Parameter T_RD, 3, read access wait cycles per beat, >=1.
REQ-005 Parameter T_WR, 4, write-enable low cycles per beat, >=1.
REQ-006 Parameter T_RST, 16, flash_rst_n low cycles and recovery cycles, >=1.
REQ-007 Parameter ARM_TO, 64, cycles a reset-arm stays valid, >=1.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 cmd_valid / cmd_ready  in / out  1  command handshake; transfer when both high.
REQ-011 cmd_op  in  5  opcode, command[15:11]: 01100 read, 10100 write, 11100 flash reset, 11101 reset-arm; others illegal.
REQ-012 cmd_addr  in  ADDR_W  start address; cmd_len  in  LEN_W  beats minus one.
REQ-013 wr_data / wr_valid / wr_ready  in / in / out  DATA_W/1/1  write data handshake.
REQ-014 rd_data / rd_valid  out  DATA_W/1  read beat; no backpressure.
REQ-015 flash_addr  out  ADDR_W; flash_dq_in  in  DATA_W; flash_dq_out  out  DATA_W; flash_dq_oe  out  1.
REQ-016 flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n  out  1  active-low flash strobes.
REQ-017 busy  out  1  high when state != IDLE; err  out  1  one-cycle pulse on rejected command.

Function
REQ-018 States: IDLE, RD_WAIT, RD_CAP, WR_DATA, WR_PULSE, WR_REC, RST_PULSE, RST_REC.
REQ-019 cmd_ready = 1 only in IDLE; opcode, address, length latched on the accepting edge.
REQ-020 Read: RD_WAIT for T_RD cycles with ce_n=0, oe_n=0, flash_addr=current address; RD_CAP samples flash_dq_in; rd_data valid with rd_valid=1 for exactly one cycle, T_RD+1 cycles after entering RD_WAIT.
REQ-021 After each read beat: beats remaining -> address+1 (wrapping), back to RD_WAIT; else IDLE with ce_n=oe_n=1.
REQ-022 Write: WR_DATA holds wr_ready=1, ce_n=1; on wr_valid&&wr_ready latch wr_data to flash_dq_out, go WR_PULSE.
REQ-023 WR_PULSE: ce_n=0, we_n=0, dq_oe=1 for T_WR cycles; WR_REC: one cycle we_n=1, ce_n=0, dq_oe=1 (data hold); then next beat (address+1, WR_DATA) or IDLE.
REQ-024 flash_oe_n and flash_we_n SHALL never be low in the same cycle; dq_oe=1 only in WR_PULSE/WR_REC.
REQ-025 Reset-arm (11101) accepted in IDLE sets armed, loads arm timer ARM_TO; no flash activity, busy stays 0.
REQ-026 Flash reset (11100) while armed: RST_PULSE flash_rst_n=0 for T_RST cycles, RST_REC T_RST cycles all strobes high, then IDLE.
REQ-027 Flash reset while not armed: accepted, err pulse next cycle, no flash activity.
REQ-028 armed cleared when the timer expires or on acceptance of any command other than 11101; re-arming reloads the timer.
REQ-029 Illegal opcode: accepted, err pulse next cycle, state stays IDLE, armed cleared.
REQ-030 Timer expiry and reset-command acceptance in the same cycle: command wins (reset executes).
REQ-031 cmd_len=0 yields exactly one beat; cmd_len=2^LEN_W-1 yields 2^LEN_W beats.

Reset
REQ-032 rst_n low at a clock edge, in any state: next cycle IDLE, armed=0, timers cleared.
REQ-033 Reset values: cmd_ready=1 after release (0 while rst_n low), ce_n=oe_n=we_n=1, flash_rst_n=1, dq_oe=0, flash_dq_out=0, flash_addr=0, rd_data=0, rd_valid=0, wr_ready=0, busy=0, err=0.
REQ-034 Module reset SHALL NOT drive flash_rst_n low; flash reset only via armed command (glyph data protection).

Structure
REQ-035 Package flash_seq_pkg holds opcode constants (OP_READ, OP_WRITE, OP_RESET, OP_ARM) and the state enum.
REQ-036 Sub-module flash_seq_timer: loadable down-counter with done flag, shared by RD_WAIT, WR_PULSE, RST_PULSE, RST_REC; width $clog2(max(T_RD,T_WR,T_RST)+1).

Verification
REQ-037 Read op 01100, addr 0x00010, len 2, T_RD=3, flash model data=addr -> rd_valid pulses with 0x0010, 0x0011, 0x0012, 4 cycles apart, then IDLE.
REQ-038 Write op 10100, addr 0xFFFFF, len 1, data 0xA5A5,0x5A5A -> two we_n pulses of T_WR cycles at 0xFFFFF then 0x00000 (wrap); oe_n stays 1.
REQ-039 Op 11100 without arm -> err one cycle, flash_rst_n stays 1; 11101 then 11100 within 10 cycles -> flash_rst_n low 16 cycles, busy for 32.
REQ-040 11101, wait ARM_TO+1 cycles, 11100 -> err, no flash reset; 11101, read, 11100 -> err.
REQ-041 rst_n low mid-WR_PULSE -> next cycle we_n=1, ce_n=1, dq_oe=0, busy=0; flash_rst_n never low.
REQ-042 Illegal op 00000 -> err pulse, cmd_ready remains 1, no strobe activity.
